ofdm_symbol_sequencer: RTL and testbench
========================================

# ofdm_symbol_sequencer

Controller between the 16-QAM mapper and the IFFT core in the OFDM transmit chain. It issues the one-shot IFFT configuration after reset and frames mapper output into NFFT-sample symbols with tlast. It then captures each IFFT output symbol into a local buffer and re-emits it with a CP_LEN-sample cyclic prefix on an AXI-Stream master toward the DAC/serializer path.

## Interface
- NFFT, 8, subcarriers per symbol (power of 2, ≥ 2)
- CP_LEN, 4, cyclic-prefix length (1 ≤ CP_LEN ≤ NFFT)
- DW, 32, sample width: {re[31:16], im[15:0]}, two's complement
- CFG_WORD, 24'h000404, IFFT config word (inverse, scaling and CP fields as used by the core)

- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous, active-low
- s_sym_tdata  in  DW  mapped QAM symbol
- s_sym_tvalid  in  1  mapper valid
- s_sym_tready  out  1  sequencer ready
- cfg_tdata  out  24  constant CFG_WORD
- cfg_tvalid  out  1  config valid to IFFT
- cfg_tready  in  1  IFFT config ready
- fft_in_tdata  out  DW  to IFFT data input
- fft_in_tvalid  out  1
- fft_in_tlast  out  1  high on sample NFFT-1 of each symbol
- fft_in_tready  in  1
- fft_out_tdata  in  DW  IFFT output sample
- fft_out_tvalid  in  1
- fft_out_tlast  in  1
- fft_out_tready  out  1
- m_tdata  out  DW  CP-extended output sample
- m_tvalid  out  1
- m_tlast  out  1  high on the last sample of each CP-extended symbol
- m_tready  in  1
- sym_count  out  16  completed output symbols, wraps at 65535→0
- err_framing  out  1  sticky framing error

## Operation
- Config FSM, states CFG_SEND → CFG_DONE. cfg_tvalid=1 in CFG_SEND. The state moves to CFG_DONE on the cycle cfg_tvalid && cfg_tready. It stays in CFG_DONE until reset.
- Input path is active only in CFG_DONE. It is a combinational pass-through:
  - fft_in_tdata = s_sym_tdata
  - fft_in_tvalid = s_sym_tvalid
  - s_sym_tready = fft_in_tready
  - Before CFG_DONE, fft_in_tvalid=0 and s_sym_tready=0.
- Input counter in_idx (log2 NFFT bits) increments on each fft_in handshake and wraps NFFT-1→0. fft_in_tlast = (in_idx==NFFT-1).
- Output FSM has states CAPTURE, EMIT_CP and EMIT_BODY, and resets to CAPTURE.
- CAPTURE:
  - fft_out_tready=1 and m_tvalid=0.
  - Each fft_out handshake writes buf[wr_idx] and increments wr_idx.
  - The symbol ends on a handshake with wr_idx==NFFT-1 or with fft_out_tlast=1, whichever comes first. The FSM then goes to EMIT_CP with rd_idx=NFFT-CP_LEN and wr_idx=0.
  - err_framing is set if fft_out_tlast disagrees with (wr_idx==NFFT-1) on any handshake.
- EMIT_CP:
  - fft_out_tready=0, m_tvalid=1, m_tdata=buf[rd_idx].
  - Each m handshake increments rd_idx.
  - A handshake at rd_idx==NFFT-1 goes to EMIT_BODY with rd_idx=0.
- EMIT_BODY:
  - m_tvalid=1, m_tdata=buf[rd_idx], m_tlast=(rd_idx==NFFT-1).
  - The handshake with m_tlast returns to CAPTURE and increments sym_count.
- The buffer is NFFT×DW registers with no reset requirement. Reads are combinational from registers. m_tdata must stay stable while m_tvalid && !m_tready.
- m_tvalid drops only after a handshake (AXI-Stream rules).

## Timing
- Reset values:
  - cfg_tvalid=1 and cfg_tdata=CFG_WORD.
  - fft_in_tvalid=0, s_sym_tready=0, fft_in_tlast=0.
  - fft_out_tready=1 (state CAPTURE), m_tvalid=0, m_tlast=0.
  - sym_count=0, err_framing=0.
  - All indices are 0.
- Config: the earliest CFG_DONE is 1 cycle after the first cycle with cfg_tready=1. Input passes on the following cycle.
- Input path latency: 0 cycles (combinational).
- Output latency: the first CP sample is valid the cycle after the last capture handshake.
- Throughput with m_tready=1: NFFT capture cycles plus NFFT+CP_LEN emit cycles. That is 20 cycles per symbol at default parameters.
- The IFFT is back-pressured via fft_out_tready=0 during emission.
- Reset asserted mid-operation:
  - All state is abandoned immediately and asynchronously.
  - After release, cfg_tvalid reasserts and configuration repeats.
  - Partial symbols are discarded. No m_tvalid is issued until a full new capture.
- In-flight input count: in_idx resets to 0 on reset only. A new symbol boundary never resyncs from the mapper.

## Test plan
- Config handshake: hold cfg_tready=0 for 5 cycles after reset release, then set it to 1. Required response:
  - cfg_tvalid stays 1 for those 5 cycles, then deasserts the cycle after.
  - s_sym_tready stays 0 until CFG_DONE, then follows fft_in_tready.
- Input framing: stream 24 mapper samples with fft_in_tready=1. fft_in_tlast must be high on samples 7, 15 and 23 only.
- CP insertion: feed fft_out samples 0x0000_0000…0x0007_0007 with tlast on the 8th and hold m_tready=1. Required response:
  - m emits 0x0004_0004, 0x0005_0005, 0x0006_0006, 0x0007_0007, then 0x0000_0000…0x0007_0007.
  - m_tlast is high only on the 12th sample.
  - sym_count becomes 1.
- Backpressure: toggle m_tready randomly at 50%. Required response:
  - The output sequence is identical to the no-backpressure case, with m_tdata stable while stalled.
  - fft_out_tready=0 throughout emission.
- Framing error: assert fft_out_tlast on the 6th sample. Required response:
  - err_framing=1 and stays sticky.
  - The symbol closes early and 12 samples are still emitted from the buffer.
- Reset mid-emission: pulse aresetn low during EMIT_BODY at rd_idx=3. Required response:
  - m_tvalid=0 immediately, sym_count=0, cfg_tvalid=1.
  - The next symbol is emitted correctly after reconfiguration.

Source files
------------

// File: rtl/ofdm_symbol_sequencer_if.sv
// Bundles every stream, config and status signal between the sequencer and its neighbours.
// Latency: none, wiring only.
// Backpressure: carried by the tready members of each stream.
interface ofdm_symbol_sequencer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] s_sym_tdata;
    logic          s_sym_tvalid;
    logic          s_sym_tready;

    logic [23:0]   cfg_tdata;
    logic          cfg_tvalid;
    logic          cfg_tready;

    logic [DW-1:0] fft_in_tdata;
    logic          fft_in_tvalid;
    logic          fft_in_tlast;
    logic          fft_in_tready;

    logic [DW-1:0] fft_out_tdata;
    logic          fft_out_tvalid;
    logic          fft_out_tlast;
    logic          fft_out_tready;

    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;

    logic [15:0]   sym_count;
    logic          err_framing;

    // Sequencer side
    modport master (
        input  s_sym_tdata, s_sym_tvalid,
        output s_sym_tready,
        output cfg_tdata, cfg_tvalid,
        input  cfg_tready,
        output fft_in_tdata, fft_in_tvalid, fft_in_tlast,
        input  fft_in_tready,
        input  fft_out_tdata, fft_out_tvalid, fft_out_tlast,
        output fft_out_tready,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready,
        output sym_count, err_framing
    );

    // Environment side: mapper, IFFT core and DAC path
    modport slave (
        output s_sym_tdata, s_sym_tvalid,
        input  s_sym_tready,
        input  cfg_tdata, cfg_tvalid,
        output cfg_tready,
        input  fft_in_tdata, fft_in_tvalid, fft_in_tlast,
        output fft_in_tready,
        output fft_out_tdata, fft_out_tvalid, fft_out_tlast,
        input  fft_out_tready,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready,
        input  sym_count, err_framing
    );
endinterface

// File: rtl/ofdm_symbol_sequencer.sv
// Configures the IFFT once, frames mapper samples into symbols, re-emits IFFT output with a cyclic prefix.
// Latency: input path 0 cycles; first CP sample valid the cycle after the last capture handshake.
// Backpressure: s_sym follows fft_in_tready; IFFT output is held off (fft_out_tready=0) while emitting.
module ofdm_symbol_sequencer #(
    parameter int          NFFT     = 8,
    parameter int          CP_LEN   = 4,
    parameter int          DW       = 32,
    parameter logic [23:0] CFG_WORD = 24'h000404
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    ofdm_symbol_sequencer_if.master bus
);
    localparam int             AW       = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(NFFT - 1);
    localparam logic [AW-1:0]  CP_START = AW'(NFFT - CP_LEN);

    typedef enum logic {CFG_SEND, CFG_DONE} cfg_state_t;
    typedef enum logic [1:0] {CAPTURE, EMIT_CP, EMIT_BODY} out_state_t;

    cfg_state_t    cfg_state, cfg_state_nxt;
    logic          cfg_tvalid_c;
    logic          cfg_done;

    logic [AW-1:0] in_idx;
    logic          in_hs;

    out_state_t    out_state, out_state_nxt;
    logic [AW-1:0] wr_idx, wr_idx_nxt;
    logic [AW-1:0] rd_idx, rd_idx_nxt;
    logic [15:0]   sym_count_q, sym_count_nxt;
    logic          err_q, err_nxt;
    logic          buf_we;
    logic          fft_out_tready_c, m_tvalid_c, m_tlast_c;

    logic [DW-1:0] sym_buf [NFFT];

    // ---------------- configuration ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cfg_state <= CFG_SEND;
        else          cfg_state <= cfg_state_nxt;
    end

    always_comb begin
        cfg_state_nxt = cfg_state;
        cfg_tvalid_c  = 1'b0;
        case (cfg_state)
            CFG_SEND: begin
                cfg_tvalid_c = 1'b1;
                if (bus.cfg_tready) cfg_state_nxt = CFG_DONE;
            end
            default: cfg_state_nxt = CFG_DONE;
        endcase
    end

    assign cfg_done       = (cfg_state == CFG_DONE);
    assign bus.cfg_tvalid = cfg_tvalid_c;
    assign bus.cfg_tdata  = CFG_WORD;

    // ---------------- input framing ----------------
    assign bus.fft_in_tdata  = bus.s_sym_tdata;
    assign bus.fft_in_tvalid = cfg_done & bus.s_sym_tvalid;
    assign bus.s_sym_tready  = cfg_done & bus.fft_in_tready;
    assign bus.fft_in_tlast  = (in_idx == LAST_IDX);
    assign in_hs             = bus.fft_in_tvalid & bus.fft_in_tready;

    // Counts free-running across symbols; only reset realigns it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   in_idx <= '0;
        else if (in_hs) in_idx <= in_idx + AW'(1);
    end

    // ---------------- capture / emit ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_state   <= CAPTURE;
            wr_idx      <= '0;
            rd_idx      <= '0;
            sym_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            out_state   <= out_state_nxt;
            wr_idx      <= wr_idx_nxt;
            rd_idx      <= rd_idx_nxt;
            sym_count_q <= sym_count_nxt;
            err_q       <= err_nxt;
        end
    end

    always_comb begin
        out_state_nxt    = out_state;
        wr_idx_nxt       = wr_idx;
        rd_idx_nxt       = rd_idx;
        sym_count_nxt    = sym_count_q;
        err_nxt          = err_q;
        buf_we           = 1'b0;
        fft_out_tready_c = 1'b0;
        m_tvalid_c       = 1'b0;
        m_tlast_c        = 1'b0;
        case (out_state)
            CAPTURE: begin
                fft_out_tready_c = 1'b1;
                if (bus.fft_out_tvalid) begin
                    buf_we = 1'b1;
                    if (bus.fft_out_tlast != (wr_idx == LAST_IDX)) err_nxt = 1'b1;
                    // An early tlast still closes the symbol; stale slots are emitted as-is.
                    if ((wr_idx == LAST_IDX) || bus.fft_out_tlast) begin
                        out_state_nxt = EMIT_CP;
                        wr_idx_nxt    = '0;
                        rd_idx_nxt    = CP_START;
                    end else begin
                        wr_idx_nxt = wr_idx + AW'(1);
                    end
                end
            end
            EMIT_CP: begin
                m_tvalid_c = 1'b1;
                if (bus.m_tready) begin
                    if (rd_idx == LAST_IDX) begin
                        out_state_nxt = EMIT_BODY;
                        rd_idx_nxt    = '0;
                    end else begin
                        rd_idx_nxt = rd_idx + AW'(1);
                    end
                end
            end
            EMIT_BODY: begin
                m_tvalid_c = 1'b1;
                m_tlast_c  = (rd_idx == LAST_IDX);
                if (bus.m_tready) begin
                    if (rd_idx == LAST_IDX) begin
                        out_state_nxt = CAPTURE;
                        rd_idx_nxt    = '0;
                        sym_count_nxt = sym_count_q + 16'd1;
                    end else begin
                        rd_idx_nxt = rd_idx + AW'(1);
                    end
                end
            end
            default: out_state_nxt = CAPTURE;
        endcase
    end

    // Sample storage carries no reset; contents are only read after a full capture.
    always_ff @(posedge aclk) begin
        if (buf_we) sym_buf[wr_idx] <= bus.fft_out_tdata;
    end

    assign bus.fft_out_tready = fft_out_tready_c;
    assign bus.m_tvalid       = m_tvalid_c;
    assign bus.m_tlast        = m_tlast_c;
    assign bus.m_tdata        = sym_buf[rd_idx];
    assign bus.sym_count      = sym_count_q;
    assign bus.err_framing    = err_q;
endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Bench for ofdm_symbol_sequencer: directed vectors, a queue-based reference model checked every cycle,
// plus literal expectations for the configuration, framing, CP order, error and reset scenarios.
`timescale 1ns/1ps
module tb_ofdm_symbol_sequencer;
    localparam int NFFT   = 8;
    localparam int CP_LEN = 4;
    localparam int DW     = 32;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    ofdm_symbol_sequencer_if #(.DW(DW)) bus ();

    ofdm_symbol_sequencer #(
        .NFFT(NFFT), .CP_LEN(CP_LEN), .DW(DW), .CFG_WORD(24'h000404)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          cfg_done_m;
    int          in_cnt;
    logic [31:0] mbuf [NFFT];
    int          wpos;
    logic [31:0] exp_q [$];
    int          exp_sym;
    bit          exp_err;
    bit          stall_prev;
    logic [31:0] stall_data;
    logic [31:0] got_q [$];
    bit          got_last [$];
    bit          bp_mode = 1'b0;

    // Outputs are checked at the falling edge, then the model advances for the coming rising edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            cfg_done_m = 1'b0;
            in_cnt     = 0;
            wpos       = 0;
            exp_q.delete();
            exp_sym    = 0;
            exp_err    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("cfg_tvalid", 32'(bus.cfg_tvalid), 32'(!cfg_done_m));
            check("cfg_tdata", 32'(bus.cfg_tdata), 32'h000404);
            check("s_sym_tready", 32'(bus.s_sym_tready), 32'(cfg_done_m && bus.fft_in_tready));
            check("fft_in_tvalid", 32'(bus.fft_in_tvalid), 32'(cfg_done_m && bus.s_sym_tvalid));
            if (bus.fft_in_tvalid) begin
                check("fft_in_tdata", bus.fft_in_tdata, bus.s_sym_tdata);
                check("fft_in_tlast", 32'(bus.fft_in_tlast), 32'((in_cnt % NFFT) == NFFT - 1));
            end
            check("m_tvalid", 32'(bus.m_tvalid), 32'(exp_q.size() != 0));
            check("fft_out_tready", 32'(bus.fft_out_tready), 32'(exp_q.size() == 0));
            check("sym_count", 32'(bus.sym_count), 32'(exp_sym));
            check("err_framing", 32'(bus.err_framing), 32'(exp_err));
            if (bus.m_tvalid && exp_q.size() != 0) begin
                check("m_tdata", bus.m_tdata, exp_q[0]);
                check("m_tlast", 32'(bus.m_tlast), 32'(exp_q.size() == 1));
            end
            if (stall_prev && bus.m_tvalid)
                check("m_tdata_stable", bus.m_tdata, stall_data);

            if (cfg_done_m && bus.s_sym_tvalid && bus.fft_in_tready) in_cnt++;
            if (!cfg_done_m && bus.cfg_tready) cfg_done_m = 1'b1;

            if (exp_q.size() == 0 && bus.fft_out_tvalid) begin
                mbuf[wpos] = bus.fft_out_tdata;
                if (bus.fft_out_tlast != (wpos == NFFT - 1)) exp_err = 1'b1;
                if (wpos == NFFT - 1 || bus.fft_out_tlast) begin
                    for (int k = 0; k < CP_LEN; k++) exp_q.push_back(mbuf[NFFT - CP_LEN + k]);
                    for (int k = 0; k < NFFT; k++) exp_q.push_back(mbuf[k]);
                    wpos = 0;
                end else begin
                    wpos++;
                end
            end

            if (bus.m_tvalid && bus.m_tready && exp_q.size() != 0) begin
                got_q.push_back(bus.m_tdata);
                got_last.push_back(bus.m_tlast);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_sym = (exp_sym + 1) % 65536;
            end
            stall_prev = bus.m_tvalid && !bus.m_tready;
            stall_data = bus.m_tdata;
        end
    end

    // m_tready driver: always ready, or a 50% random pattern when bp_mode is set.
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_fft(input logic [31:0] d, input logic last);
        int cyc = 0;
        bus.fft_out_tdata  = d;
        bus.fft_out_tvalid = 1'b1;
        bus.fft_out_tlast  = last;
        @(negedge aclk);
        while (!bus.fft_out_tready && cyc < 300) begin
            @(negedge aclk);
            cyc++;
        end
        if (cyc >= 300) check("fft_out_wait_bound", 32'(cyc), 32'(0));
        @(posedge aclk);
        #1;
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int cyc = 0;
        while (got_q.size() < n && cyc < 400) begin
            @(posedge aclk);
            cyc++;
        end
        #1;
        check("emitted_count", 32'(got_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] cp_order(input int k);
        int v;
        v = (k < CP_LEN) ? (NFFT - CP_LEN + k) : (k - CP_LEN);
        return {16'(v), 16'(v)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] tl_mask;
        logic [11:0] last_mask;
        int          cyc;

        bus.s_sym_tdata    = '0;
        bus.s_sym_tvalid   = 1'b0;
        bus.cfg_tready     = 1'b0;
        bus.fft_in_tready  = 1'b0;
        bus.fft_out_tdata  = '0;
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;

        // Reset values
        repeat (3) @(posedge aclk);
        #1;
        check("rst_cfg_tvalid", 32'(bus.cfg_tvalid), 32'd1);
        check("rst_cfg_tdata", 32'(bus.cfg_tdata), 32'h000404);
        check("rst_fft_in_tvalid", 32'(bus.fft_in_tvalid), 32'd0);
        check("rst_s_sym_tready", 32'(bus.s_sym_tready), 32'd0);
        check("rst_fft_in_tlast", 32'(bus.fft_in_tlast), 32'd0);
        check("rst_fft_out_tready", 32'(bus.fft_out_tready), 32'd1);
        check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
        check("rst_sym_count", 32'(bus.sym_count), 32'd0);
        check("rst_err", 32'(bus.err_framing), 32'd0);
        aresetn = 1'b1;
        bus.fft_in_tready = 1'b1;

        // Config handshake held off for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            check("cfg_hold_tvalid", 32'(bus.cfg_tvalid), 32'd1);
            check("cfg_hold_s_tready", 32'(bus.s_sym_tready), 32'd0);
        end
        bus.cfg_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("cfg_done_tvalid", 32'(bus.cfg_tvalid), 32'd0);
        check("cfg_done_s_tready", 32'(bus.s_sym_tready), 32'd1);
        bus.fft_in_tready = 1'b0;
        #1;
        check("s_tready_follows", 32'(bus.s_sym_tready), 32'd0);
        bus.fft_in_tready = 1'b1;

        // Input framing over 24 samples
        tl_mask = '0;
        for (int i = 0; i < 24; i++) begin
            bus.s_sym_tdata  = {16'(i), 16'(i + 100)};
            bus.s_sym_tvalid = 1'b1;
            #1;
            tl_mask[i] = bus.fft_in_tlast;
            @(posedge aclk);
            #1;
        end
        bus.s_sym_tvalid = 1'b0;
        check("in_tlast_positions", 32'(tl_mask), 32'h808080);

        // CP insertion, no backpressure
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < NFFT; i++) send_fft({16'(i), 16'(i)}, i == NFFT - 1);
        wait_got(NFFT + CP_LEN);
        last_mask = '0;
        for (int k = 0; k < got_q.size() && k < 12; k++) last_mask[k] = got_last[k];
        check("cp_first", got_q[0], 32'h00040004);
        check("cp_fourth", got_q[3], 32'h00070007);
        check("body_first", got_q[4], 32'h00000000);
        check("body_last", got_q[11], 32'h00070007);
        check("m_tlast_positions", 32'(last_mask), 32'h800);
        check("sym_count_1", 32'(bus.sym_count), 32'd1);

        // Same symbol under random m_tready
        bp_mode = 1'b1;
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < NFFT; i++) send_fft({16'(i), 16'(i)}, i == NFFT - 1);
        wait_got(NFFT + CP_LEN);
        bp_mode = 1'b0;
        for (int k = 0; k < got_q.size() && k < 12; k++) check("bp_order", got_q[k], cp_order(k));
        check("sym_count_2", 32'(bus.sym_count), 32'd2);

        // Early tlast on the 6th sample
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < 6; i++) send_fft(32'hA0000000 + 32'(i), i == 5);
        wait_got(NFFT + CP_LEN);
        check("err_set", 32'(bus.err_framing), 32'd1);
        check("err_cp0", got_q[0], 32'hA0000004);
        check("err_cp1", got_q[1], 32'hA0000005);
        check("err_stale6", got_q[2], 32'h00060006);
        check("err_body0", got_q[4], 32'hA0000000);
        check("err_body7", got_q[11], 32'h00070007);
        check("err_tlast", 32'(got_last[11]), 32'd1);
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < NFFT; i++) send_fft(32'hB0000000 + 32'(i), i == NFFT - 1);
        wait_got(NFFT + CP_LEN);
        check("err_sticky", 32'(bus.err_framing), 32'd1);
        check("sym_count_4", 32'(bus.sym_count), 32'd4);

        // Reset during body emission at rd_idx=3
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < NFFT; i++) send_fft(32'hC0000000 + 32'(i), i == NFFT - 1);
        cyc = 0;
        while (got_q.size() < CP_LEN + 3 && cyc < 100) begin
            @(posedge aclk);
            cyc++;
        end
        check("pre_reset_count", 32'(got_q.size()), 32'(CP_LEN + 3));
        #1;
        check("pre_reset_data", bus.m_tdata, 32'hC0000003);
        aresetn = 1'b0;
        #1;
        check("mid_rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("mid_rst_sym_count", 32'(bus.sym_count), 32'd0);
        check("mid_rst_cfg_tvalid", 32'(bus.cfg_tvalid), 32'd1);
        check("mid_rst_err", 32'(bus.err_framing), 32'd0);
        check("mid_rst_fft_out_tready", 32'(bus.fft_out_tready), 32'd1);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("recfg_tvalid", 32'(bus.cfg_tvalid), 32'd0);
        got_q.delete();
        got_last.delete();
        for (int i = 0; i < NFFT; i++) send_fft(32'hD0000000 + 32'(i), i == NFFT - 1);
        wait_got(NFFT + CP_LEN);
        check("post_rst_cp0", got_q[0], 32'hD0000004);
        check("post_rst_body0", got_q[4], 32'hD0000000);
        check("post_rst_body7", got_q[11], 32'hD0000007);
        check("post_rst_sym_count", 32'(bus.sym_count), 32'd1);

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
